// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle HI/LO multiply/divide sequencer.
//   Runs MULTU/MULT/DIVU/DIV as ITER shift-add / restoring-subtract steps and
//   drives the shared 32-bit adder (alu_a/alu_b/alu_func0/alu_sign out,
//   alu_s/alu_v/alu_n in, used combinationally in the same cycle).
// Ports:
//   clk, reset (sync, active-low)
//   start, op[1:0] (00 MULTU, 01 MULT, 10 DIVU, 11 DIV), a, b : request
//   busy, done, hi, lo, div_zero                              : status/result
//   alu_a, alu_b, alu_func0, alu_sign / alu_s, alu_v, alu_n   : shared adder
// Configuration macro: MULDIV_ZERO_SKIP_EN (skip the step loop for trivial
//   zero operands; results are identical, only latency changes).
module muldiv_seq #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_func0,
  output logic        alu_sign,
  input  logic [31:0] alu_s,
  input  logic        alu_v,
  input  logic        alu_n
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] acc_hi_q, acc_hi_d;   // MUL: H, DIV: R
  logic [31:0] acc_lo_q, acc_lo_d;   // MUL: L, DIV: Q
  logic [31:0] mcand_q, mcand_d;     // MUL: M, DIV: D
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        raw_q, raw_d;         // acc already holds the final result
  logic        hold_q, hold_d;       // extra FIX cycle on the skip paths
  logic        dz_pend_q, dz_pend_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        div_zero_q, div_zero_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] mag_a, mag_b;
  logic [63:0] prod, prod_neg;
  logic [31:0] fix_hi, fix_lo;
  logic        skip;

  // Local magnitude logic; the shared adder is only used for the steps.
  assign mag_a    = (op[0] && a[31]) ? (~a + 32'd1) : a;
  assign mag_b    = (op[0] && b[31]) ? (~b + 32'd1) : b;
  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_neg = ~prod + 64'd1;

`ifdef MULDIV_ZERO_SKIP_EN
  assign skip = op[1] ? ((a == '0) && (b != '0)) : ((a == '0) || (b == '0));
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    fix_hi = acc_hi_q;
    fix_lo = acc_lo_q;
    if (!raw_q) begin
      if (is_div_q) begin
        if (neg_res_q) fix_lo = ~acc_lo_q + 32'd1;
        if (neg_rem_q) fix_hi = ~acc_hi_q + 32'd1;
      end else if (neg_res_q) begin
        {fix_hi, fix_lo} = prod_neg;
      end
    end
  end

  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_func0 = 1'b0;
    if (state_q == S_ITER) begin
      alu_b = mcand_q;
      if (is_div_q) begin
        alu_a     = {acc_hi_q[30:0], acc_lo_q[31]};
        alu_func0 = 1'b1;
      end else begin
        alu_a = acc_hi_q;
      end
    end
  end

  assign alu_sign = 1'b0;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    mcand_d    = mcand_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    raw_d      = raw_q;
    hold_d     = hold_q;
    dz_pend_d  = dz_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d     = 1'b1;
          count_d    = '0;
          div_zero_d = 1'b0;
          is_div_d   = op[1];
          neg_res_d  = op[0] & (a[31] ^ b[31]);
          neg_rem_d  = op[0] & a[31];
          dz_pend_d  = 1'b0;
          raw_d      = 1'b0;
          hold_d     = 1'b0;
          acc_hi_d   = '0;
          acc_lo_d   = mag_a;
          mcand_d    = mag_b;
          state_d    = S_ITER;
          if (op[1] && (b == '0)) begin
            acc_hi_d  = a;
            acc_lo_d  = '1;
            dz_pend_d = 1'b1;
            raw_d     = 1'b1;
            hold_d    = 1'b1;
            state_d   = S_FIX;
          end else if (skip) begin
            acc_lo_d = '0;
            raw_d    = 1'b1;
            hold_d   = 1'b1;
            state_d  = S_FIX;
          end
        end
      end
      S_ITER: begin
        if (is_div_q) begin
          if (acc_hi_q[31] || !alu_n) begin
            acc_hi_d = alu_s;
            acc_lo_d = {acc_lo_q[30:0], 1'b1};
          end else begin
            acc_hi_d = alu_a;
            acc_lo_d = {acc_lo_q[30:0], 1'b0};
          end
        end else if (acc_lo_q[0]) begin
          {acc_hi_d, acc_lo_d} = {alu_v, alu_s, acc_lo_q[31:1]};
        end else begin
          {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[31:1]};
        end
        count_d = count_q + 5'd1;
        if (count_q == 5'(ITER - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (hold_q) begin
          hold_d = 1'b0;
        end else begin
          state_d    = S_DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          hi_d       = fix_hi;
          lo_d       = fix_lo;
          div_zero_d = dz_pend_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      mcand_q    <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      raw_q      <= 1'b0;
      hold_q     <= 1'b0;
      dz_pend_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      mcand_q    <= mcand_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      raw_q      <= raw_d;
      hold_q     <= hold_d;
      dz_pend_q  <= dz_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq, with a
// behavioural model of the shared 32-bit adder.
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_zero, alu_func0, alu_sign;
  logic [31:0] hi, lo, alu_a, alu_b;
  logic [31:0] alu_s;
  logic        alu_v, alu_n;
  logic [32:0] add33;

  int errors = 0;
  int checks = 0;

`ifdef MULDIV_ZERO_SKIP_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 33;
`endif

  always #5 clk = ~clk;

  assign add33 = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_s = alu_func0 ? (alu_a - alu_b) : add33[31:0];
  assign alu_v = alu_func0 ? 1'b0 : add33[32];
  assign alu_n = alu_func0 ? (alu_a < alu_b) : 1'b0;

  muldiv_seq #(.ITER(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func0(alu_func0), .alu_sign(alu_sign),
    .alu_s(alu_s), .alu_v(alu_v), .alu_n(alu_n)
  );

  // Starting at a negedge after the accepting edge: counts edges until done
  // is seen (-1 on timeout), tracks busy/hi/lo stability and alu_v activity.
  task automatic wait_done(output int lat, output bit stable, output bit saw_v);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo; stable = 1'b1; saw_v = 1'b0; lat = -1;
    for (int i = 1; i <= 100; i++) begin
      if (!busy || hi !== h0 || lo !== l0) stable = 1'b0;
      if (alu_v) saw_v = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output bit stable, output bit saw_v);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, stable, saw_v);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin errors++; $display("FAIL reset_flags: busy=%b done=%b dz=%b, want 0 0 0", busy, done, div_zero); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_hilo: hi=%h lo=%h, want 0 0", hi, lo); end
    checks++; if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_func0 !== 1'b0 || alu_sign !== 1'b0) begin errors++; $display("FAIL reset_alu: a=%h b=%h f=%b s=%b, want 0", alu_a, alu_b, alu_func0, alu_sign); end
    reset = 1'b1;
  endtask

  task automatic test_mul;
    int lat; bit st, sv;
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, st, sv);
    checks++; if (lat !== 33) begin errors++; $display("FAIL multu_latency: got %0d want 33", lat); end
    checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_result: hi=%h lo=%h want fffffffe 00000001", hi, lo); end
    checks++; if (sv !== 1'b1) begin errors++; $display("FAIL multu_carry: alu_v seen=%b want 1", sv); end
    checks++; if (st !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL multu_busy: stable=%b busy_at_done=%b want 1 0", st, busy); end
    do_op(2'b01, 32'hFFFF_FFFD, 32'd7, lat, st, sv);
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_neg: hi=%h lo=%h want ffffffff ffffffeb", hi, lo); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL mult_stable: stable=%b want 1", st); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: done=%b want 0", done); end
  endtask

  task automatic test_div;
    int lat; bit st, sv;
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat, st, sv);
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency: got %0d want 33", lat); end
    checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg: hi=%h lo=%h want ffffffff fffffffd", hi, lo); end
    do_op(2'b10, 32'h8000_0000, 32'd3, lat, st, sv);
    checks++; if (lo !== 32'h2AAA_AAAA || hi !== 32'd2) begin errors++; $display("FAIL divu: hi=%h lo=%h want 00000002 2aaaaaaa", hi, lo); end
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, st, sv);
    checks++; if (lo !== 32'h8000_0000 || hi !== 32'h0) begin errors++; $display("FAIL div_wrap: hi=%h lo=%h want 0 80000000", hi, lo); end
    do_op(2'b11, 32'd7, 32'hFFFF_FFFE, lat, st, sv);
    checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin errors++; $display("FAIL div_negb: hi=%h lo=%h want 00000001 fffffffd", hi, lo); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL div_nozero: dz=%b want 0", div_zero); end
  endtask

  task automatic test_div_zero;
    int lat; bit st, sv;
    do_op(2'b10, 32'd5, 32'd0, lat, st, sv);
    checks++; if (lat !== 2) begin errors++; $display("FAIL dz_latency: got %0d want 2", lat); end
    checks++; if (div_zero !== 1'b1 || hi !== 32'd5 || lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_result: dz=%b hi=%h lo=%h want 1 00000005 ffffffff", div_zero, hi, lo); end
    @(negedge clk);
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_hold: dz=%b want 1", div_zero); end
    start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_clear: dz=%b want 0", div_zero); end
    wait_done(lat, st, sv);
    checks++; if (lo !== 32'd6 || hi !== 32'd0) begin errors++; $display("FAIL dz_next: hi=%h lo=%h want 0 6", hi, lo); end
  endtask

  task automatic test_start_ignored;
    int lat; bit st, sv;
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) begin @(posedge clk); @(negedge clk); end
    start = 1'b1; op = 2'b10; a = 32'd1; b = 32'd1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, st, sv);
    checks++; if (lat + 11 !== 33) begin errors++; $display("FAIL ignore_latency: got %0d want 33", lat + 11); end
    checks++; if (lo !== 32'd42 || hi !== 32'd0) begin errors++; $display("FAIL ignore_result: hi=%h lo=%h want 0 0000002a", hi, lo); end
  endtask

  task automatic test_reset_mid;
    int lat; bit st, sv;
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd100;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (20) begin @(posedge clk); @(negedge clk); end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL midreset: busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo); end
    checks++; if (alu_a !== 32'h0 || alu_b !== 32'h0) begin errors++; $display("FAIL midreset_alu: a=%h b=%h want 0 0", alu_a, alu_b); end
    repeat (3) begin @(posedge clk); @(negedge clk); end
    checks++; if (done !== 1'b0 || hi !== 32'h0) begin errors++; $display("FAIL midreset_nolate: done=%b hi=%h want 0 0", done, hi); end
    do_op(2'b01, 32'hFFFF_FFFD, 32'd7, lat, st, sv);
    checks++; if (lat !== 33 || lo !== 32'hFFFF_FFEB || hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL midreset_fresh: lat=%0d hi=%h lo=%h want 33 ffffffff ffffffeb", lat, hi, lo); end
  endtask

  task automatic test_zero_operand;
    int lat; bit st, sv;
    do_op(2'b00, 32'd0, 32'd9, lat, st, sv);
    checks++; if (lat !== ZLAT) begin errors++; $display("FAIL zero_latency: got %0d want %0d", lat, ZLAT); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0 || div_zero !== 1'b0) begin errors++; $display("FAIL zero_result: hi=%h lo=%h dz=%b want 0 0 0", hi, lo, div_zero); end
    do_op(2'b11, 32'd0, 32'hFFFF_FFFB, lat, st, sv);
    checks++; if (lat !== ZLAT || hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL zero_div: lat=%0d hi=%h lo=%h want %0d 0 0", lat, hi, lo, ZLAT); end
  endtask

  task automatic test_back_to_back;
    int lat; bit st, sv;
    do_op(2'b00, 32'd3, 32'd5, lat, st, sv);
    // now in the DONE cycle: request the next op immediately
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy=%b want 0", busy); end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1 || lo !== 32'd15) begin errors++; $display("FAIL b2b_accept: busy=%b lo=%h want 1 0000000f", busy, lo); end
    wait_done(lat, st, sv);
    checks++; if (lat !== 33 || lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL b2b_result: lat=%0d hi=%h lo=%h want 33 2 e", lat, hi, lo); end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_div;
    test_div_zero;
    test_start_ignored;
    test_reset_mid;
    test_zero_operand;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
